// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/mask types, mem_responder states and default sizing
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} mem_responder_state_e;
  localparam int LC3B_MEM_LATENCY = 3;
  localparam int LC3B_MEM_ADDR_WIDTH = 10;
endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: 2**ADDR_WIDTH x 16 word store, per-byte write lanes, registered read, no reset
module mem_responder_array
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = LC3B_MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_idx,
  input  lc3b_word              i_wdata,
  input  lc3b_mem_wmask         i_wmask,
  input  logic                  i_we,
  input  logic                  i_re,
  output lc3b_word              o_rdata
);
  lc3b_word r_mem [0:(1<<ADDR_WIDTH)-1];
  lc3b_word r_rdata;
  always_ff @(posedge clk) begin
    if (i_we && i_wmask[0]) r_mem[i_idx][7:0] <= i_wdata[7:0];
    if (i_we && i_wmask[1]) r_mem[i_idx][15:8] <= i_wdata[15:8];
    if (i_re) r_rdata <= r_mem[i_idx];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: LC-3b memory handshake responder, fixed LATENCY, byte-lane writes; MEM_RESPONDER_PROTO_CHECK_EN builds the sticky proto_err checker
module mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = LC3B_MEM_ADDR_WIDTH,
  parameter int LATENCY    = LC3B_MEM_LATENCY
) (
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          proto_err
);
  localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  mem_responder_state_e r_state, w_next;
  logic [3:0] r_cnt;
  logic r_wr, r_has_rd;
  logic [ADDR_WIDTH-1:0] r_idx, w_idx;
  lc3b_word r_wdata, w_wdata, w_q;
  lc3b_mem_wmask r_be, w_be;
  logic w_req, w_hold, w_acc, w_fire, w_op_wr, w_unused;
  assign w_unused = &{1'b0, mem_address[15:ADDR_WIDTH+1], mem_address[0]};
  assign w_req = mem_read | mem_write;
  assign w_hold = r_wr ? mem_write : mem_read;
  assign w_acc = r_state == ST_IDLE && w_req;
  always_comb begin
    w_next = r_state;
    w_next = r_state == ST_IDLE ? (w_req ? (LATENCY == 1 ? ST_RESP : ST_WAIT) : ST_IDLE)
           : r_state == ST_WAIT ? (!w_hold ? ST_IDLE : (r_cnt == '0 ? ST_RESP : ST_WAIT))
           : ST_IDLE;
  end
  // With LATENCY=1 the access happens on the accepting edge, so use live inputs in IDLE.
  assign w_op_wr = r_state == ST_IDLE ? mem_write : r_wr;
  assign w_idx = r_state == ST_IDLE ? mem_address[ADDR_WIDTH:1] : r_idx;
  assign w_wdata = r_state == ST_IDLE ? mem_wdata : r_wdata;
  assign w_be = r_state == ST_IDLE ? mem_byte_enable : r_be;
  // rst_n gate keeps an asserted reset from committing a LATENCY=1 access.
  assign w_fire = w_next == ST_RESP && rst_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_wr <= 1'b0;
      r_idx <= '0;
      r_wdata <= '0;
      r_be <= '0;
      r_has_rd <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_wr <= mem_write;
        r_idx <= mem_address[ADDR_WIDTH:1];
        r_wdata <= mem_wdata;
        r_be <= mem_byte_enable;
        r_cnt <= CNT_INIT;
      end else if (r_state == ST_WAIT && r_cnt != '0) r_cnt <= r_cnt - 4'd1;
      if (w_fire && !w_op_wr) r_has_rd <= 1'b1;
    end
  end
  mem_responder_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk(clk),
    .i_idx(w_idx),
    .i_wdata(w_wdata),
    .i_wmask(w_be),
    .i_we(w_fire && w_op_wr),
    .i_re(w_fire && !w_op_wr),
    .o_rdata(w_q)
  );
  // The array read register has no reset, so mask it until the first read response.
  assign mem_rdata = r_has_rd ? w_q : '0;
  assign mem_resp = r_state == ST_RESP;
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  lc3b_word r_addr;
  logic r_err, w_viol;
  assign w_viol = (r_state == ST_IDLE && mem_read && mem_write)
               || (r_state == ST_WAIT && (!w_hold || mem_address != r_addr))
               || (w_acc && mem_write && mem_byte_enable == 2'b00);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_acc) r_addr <= mem_address;
      if (w_viol) r_err <= 1'b1;
    end
  end
  assign proto_err = r_err;
`else
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder at LATENCY=3 (index 0) and LATENCY=1 (index 1)
module tb_mem_responder;
`ifdef MEM_RESPONDER_PROTO_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] addr [2];
  logic [15:0] wdata [2];
  logic rd [2];
  logic wr [2];
  logic [1:0] be [2];
  logic [15:0] rdata [2];
  logic resp [2];
  logic perr [2];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mem_address(addr[0]), .mem_wdata(wdata[0]),
    .mem_read(rd[0]), .mem_write(wr[0]), .mem_byte_enable(be[0]),
    .mem_rdata(rdata[0]), .mem_resp(resp[0]), .proto_err(perr[0])
  );
  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mem_address(addr[1]), .mem_wdata(wdata[1]),
    .mem_read(rd[1]), .mem_write(wr[1]), .mem_byte_enable(be[1]),
    .mem_rdata(rdata[1]), .mem_resp(resp[1]), .proto_err(perr[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_resp"}, 32'(resp[0]), 0);
    check({tag, "_rdata"}, 32'(rdata[0]), 0);
    check({tag, "_perr"}, 32'(perr[0]), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask
  // Raise a request in cycle 0, expect mem_resp in cycle lat with rdata exp_rd, then one-cycle pulse.
  task automatic txn(input int d, input string tag, input bit w, input bit r, input logic [15:0] a,
                     input logic [15:0] wd, input logic [1:0] b, input int lat, input logic [15:0] exp_rd);
    int n;
    addr[d] = a;
    wdata[d] = wd;
    be[d] = b;
    wr[d] = w;
    rd[d] = r;
    n = 0;
    do begin
      tick();
      n++;
    end while (!resp[d] && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_rdata"}, 32'(rdata[d]), 32'(exp_rd));
    wr[d] = 1'b0;
    rd[d] = 1'b0;
    tick();
    check({tag, "_pulse"}, 32'(resp[d]), 0);
  endtask
  initial begin
    bit seen;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      be[i] = 2'b11;
    end
    do_reset("rst0");
    txn(0, "pre20", 1, 0, 16'h0020, 16'h2222, 2'b11, 3, 16'h0000);
    txn(0, "t1_wr", 1, 0, 16'h0040, 16'hBEEF, 2'b11, 3, 16'h0000);
    txn(0, "t1_rd", 0, 1, 16'h0040, 16'h0000, 2'b11, 3, 16'hBEEF);
    check("t1_perr", 32'(perr[0]), 0);
    txn(0, "t2_pre", 1, 0, 16'h0010, 16'h1234, 2'b11, 3, 16'hBEEF);
    txn(0, "t2_lo", 1, 0, 16'h0010, 16'hABCD, 2'b01, 3, 16'hBEEF);
    txn(0, "t2_hi", 1, 0, 16'h0010, 16'h5600, 2'b10, 3, 16'hBEEF);
    txn(0, "t2_rd", 0, 1, 16'h0010, 16'h0000, 2'b11, 3, 16'h56CD);
    txn(0, "t2_be0", 1, 0, 16'h0010, 16'hFFFF, 2'b00, 3, 16'h56CD);
    check("t2_be0_perr", 32'(perr[0]), 32'(PC));
    txn(0, "t2_rd2", 0, 1, 16'h0010, 16'h0000, 2'b11, 3, 16'h56CD);
    do_reset("rst3");
    addr[0] = 16'h0020;
    rd[0] = 1'b1;
    tick();
    rd[0] = 1'b0;
    seen = resp[0];
    repeat (4) begin
      tick();
      seen |= resp[0];
    end
    check("t3_abort_noresp", 32'(seen), 0);
    check("t3_perr", 32'(perr[0]), 32'(PC));
    txn(0, "t3_rd", 0, 1, 16'h0020, 16'h0000, 2'b11, 3, 16'h2222);
    do_reset("rst4");
    txn(0, "t4_clr", 1, 0, 16'h0008, 16'h0000, 2'b11, 3, 16'h0000);
    txn(0, "t4_rd40", 0, 1, 16'h0040, 16'h0000, 2'b11, 3, 16'hBEEF);
    addr[0] = 16'h0008;
    wdata[0] = 16'hFFFF;
    be[0] = 2'b11;
    wr[0] = 1'b1;
    tick();
    rst_n = 1'b0;
    wr[0] = 1'b0;
    #1;
    check("t4_rst_rdata", 32'(rdata[0]), 0);
    seen = resp[0];
    repeat (2) begin
      tick();
      seen |= resp[0];
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      seen |= resp[0];
    end
    check("t4_noresp", 32'(seen), 0);
    check("t4_rdata_hold", 32'(rdata[0]), 0);
    txn(0, "t4_rd08", 0, 1, 16'h0008, 16'h0000, 2'b11, 3, 16'h0000);
    txn(0, "t6_rd40", 0, 1, 16'h0040, 16'h0000, 2'b11, 3, 16'hBEEF);
    check("t6_perr0", 32'(perr[0]), 0);
    txn(0, "t6_both", 1, 1, 16'h0030, 16'h7777, 2'b11, 3, 16'hBEEF);
    check("t6_perr", 32'(perr[0]), 32'(PC));
    txn(0, "t6_rd30", 0, 1, 16'h0030, 16'h0000, 2'b11, 3, 16'h7777);
    txn(1, "t5_wr0", 1, 0, 16'h0000, 16'hA5A5, 2'b11, 1, 16'h0000);
    txn(1, "t5_wr800", 1, 0, 16'h0800, 16'h5A5A, 2'b11, 1, 16'h0000);
    addr[1] = 16'h0001;
    rd[1] = 1'b1;
    tick();
    check("t5_c1_resp", 32'(resp[1]), 1);
    check("t5_c1_rdata", 32'(rdata[1]), 32'h5A5A);
    addr[1] = 16'h0000;
    tick();
    check("t5_c2_resp", 32'(resp[1]), 0);
    tick();
    check("t5_c3_resp", 32'(resp[1]), 1);
    check("t5_c3_rdata", 32'(rdata[1]), 32'h5A5A);
    rd[1] = 1'b0;
    tick();
    check("t5_c4_resp", 32'(resp[1]), 0);
    check("t5_perr", 32'(perr[1]), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
